// File: rtl/key_edge_detect.sv
// Multi-channel pushbutton/switch conditioner: synchroniser, debounce, level and edge strobes.
// Optional auto-repeat on held keys is enabled by defining KEY_AUTO_REPEAT_EN.
module key_edge_detect #(
    parameter int CH         = 5,
    parameter int SYNC       = 2,
    parameter int DB_CYCLES  = 1000000,
    parameter int CNT_W      = 20,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_PERIOD = 10000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in,
    input  logic [1:0]    mode,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (SYNC < 2 || DB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1 || CH < 1 ||
        ((DB_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_params
        $error("key_edge_detect: illegal parameter combination");
    end

    logic [SYNC-1:0][CH-1:0]  sync_q, sync_d;
    logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CH-1:0]            level_q, level_d;
    logic [CH-1:0]            rise_q, rise_d;
    logic [CH-1:0]            fall_q, fall_d;
    logic [CH-1:0]            sync_s;

    // Synchroniser shift: the raw input enters stage 0, the last stage feeds the debouncer.
    always_comb begin
        sync_d = {sync_q[SYNC-2:0], in};
        sync_s = sync_q[SYNC-1];
    end

    // Debounce: level follows the synchronised input only after DB_CYCLES stable samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CH; i++) begin
            if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= DB_LAST) begin
                level_d[i] = sync_s[i];
                rise_d[i]  = sync_s[i];
                fall_d[i]  = ~sync_s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Conditioner state registers; rst wins over every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REP_PERIOD - 1);

    logic [CH-1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CH-1:0]            rep_arm_q, rep_arm_d;
    logic [CH-1:0]            rep_q, rep_d;

    // Repeat timer: first interval is REP_DELAY, then REP_PERIOD; idle whenever the key is up.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        rep_d     = '0;
        for (int i = 0; i < CH; i++) begin
            if (!level_q[i] || !level_d[i]) begin
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b0;
            end else if (rep_cnt_q[i] >= (rep_arm_q[i] ? REP_PER_LAST : REP_DLY_LAST)) begin
                rep_d[i]     = 1'b1;
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
        end
    end

    // Repeat state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_arm_q <= '0;
            rep_q     <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
            rep_q     <= rep_d;
        end
    end

    assign pulse = (rise_q & {CH{mode[0]}}) | (fall_q & {CH{mode[1]}}) | (rep_q & {CH{mode[0]}});
`else
    assign pulse = (rise_q & {CH{mode[0]}}) | (fall_q & {CH{mode[1]}});
`endif

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_key_edge_detect.sv
// Directed bench for key_edge_detect: expected strobes are queued when stimulus is driven
// and compared cycle by cycle against level/rise/fall/pulse.
module tb_key_edge_detect;

    localparam int LAT = 6; // edges from the drive point to the strobe edge (SYNC + DB_CYCLES)

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] din;
    logic [1:0] mode;
    logic [1:0] level, rise, fall, pulse;

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic rst_smp = 1'b1;
    bit   mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] r;
        logic [1:0] f;
        logic [1:0] rep;
    } ev_t;
    ev_t sbq[$];

    key_edge_detect #(
        .CH(2), .SYNC(2), .DB_CYCLES(4), .CNT_W(20), .REP_DELAY(10), .REP_PERIOD(5)
    ) dut (
        .clk(clk), .rst(rst), .in(din), .mode(mode),
        .level(level), .rise(rise), .fall(fall), .pulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic push(input int cyc, input logic [1:0] r, input logic [1:0] f,
                        input logic [1:0] rep);
        ev_t e;
        e.cyc = cyc;
        e.r   = r;
        e.f   = f;
        e.rep = rep;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input int ch, input logic v);
        logic [1:0] m;
        m     = 2'b00;
        m[ch] = 1'b1;
        din[ch] = v;
        if (v) push(edge_n + LAT, m, 2'b00, 2'b00);
        else   push(edge_n + LAT, 2'b00, m, 2'b00);
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        rst_smp = rst;
    end

    initial begin : monitor
        logic [1:0] er, ef, erep, ep, exp_lvl;
        exp_lvl = 2'b00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                er = 2'b00; ef = 2'b00; erep = 2'b00;
                for (int j = sbq.size() - 1; j >= 0; j--) begin
                    if (sbq[j].cyc == edge_n) begin
                        er   = er | sbq[j].r;
                        ef   = ef | sbq[j].f;
                        erep = erep | sbq[j].rep;
                        sbq.delete(j);
                    end
                end
                if (rst_smp) begin
                    er = 2'b00; ef = 2'b00; erep = 2'b00; exp_lvl = 2'b00;
                end else begin
                    exp_lvl = (exp_lvl | er) & ~ef;
                end
                ep = (er & {2{mode[0]}}) | (ef & {2{mode[1]}}) | (erep & {2{mode[0]}});
                chk("level", level, exp_lvl);
                chk("rise", rise, er);
                chk("fall", fall, ef);
                chk("pulse", pulse, ep);
            end
        end
    end

    initial begin : stimulus
        int r_edge;
        rst  = 1'b1;
        din  = 2'b00;
        mode = 2'b01;

        // 1: reset held three cycles
        step(1);
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);

        // 2: single press then release, mode rise
        drive(0, 1'b1);
        step(10);
        drive(0, 1'b0);
        step(10);

        // 3: bounce every 2 cycles for 20 cycles, then settle high
        for (int t = 0; t < 10; t++) begin
            din[0] = (t % 2 == 0) ? 1'b1 : 1'b0;
            step(2);
        end
        drive(0, 1'b1);
        step(10);
        drive(0, 1'b0);
        step(10);

        // 4: mode both, mode none, simultaneous channels with a same-cycle mode change
        mode = 2'b11;
        drive(0, 1'b1);
        step(10);
        drive(0, 1'b0);
        step(10);
        mode = 2'b00;
        drive(0, 1'b1);
        step(10);
        drive(0, 1'b0);
        step(10);
        din = 2'b11;
        push(edge_n + LAT, 2'b11, 2'b00, 2'b00);
        step(LAT);
        mode = 2'b01;
        step(4);
        din = 2'b00;
        push(edge_n + LAT, 2'b00, 2'b11, 2'b00);
        step(10);

        // 5: reset during a debounce window
        din[1] = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push(edge_n + LAT, 2'b10, 2'b00, 2'b00);
        step(10);
        drive(1, 1'b0);
        step(10);

        // 6: long hold (auto-repeat when built in), then release
        mode = 2'b01;
        r_edge = edge_n + LAT;
        drive(0, 1'b1);
`ifdef KEY_AUTO_REPEAT_EN
        for (int t = 10; t < 46; t += 5) push(r_edge + t, 2'b00, 2'b00, 2'b01);
`endif
        step(LAT + 40);
        drive(0, 1'b0);
        step(20);

        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
